// File: rtl/sc_levelseq_pkg.sv
// Shared definitions for the level sequencer and the lane registers that consume
// its level code: state encoding and the default level-code geometry.
package sc_levelseq_pkg;

  localparam int unsigned STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_GAMEOVER = 3'd4,
    ST_WIN      = 3'd5
  } state_e;

  // Lanes and sequencer must agree on these.
  localparam int unsigned DATAWIDTH_NVL_DEF = 2;
  localparam int unsigned NUM_LEVELS_DEF    = 4;

endpackage

// File: rtl/sc_levelseq_timer.sv
// Loadable down-counter that paces the SETTLE phase.
// Ports: clk, reset (sync, active-high), load/value (preset), enable (count down),
//        last (registered, high while count == 1).
module sc_levelseq_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // last is produced alongside the count so it is registered and aligned with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      last  <= 1'b0;
    end else if (load) begin
      count <= value;
      last  <= (value == WIDTH'(1));
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
      last  <= (count == WIDTH'(2));
    end
  end

endmodule

// File: rtl/sc_levelseq.sv
// Game-level sequencer: owns the level code and the change-level strobe for all
// vehicle lanes, tracks lives, and gates motion through the run enable.
// Ports: SC_LEVELSEQ_CLOCK_50 / SC_LEVELSEQ_RESET (sync, active-high);
//        START/GOAL/CRASH one-cycle event pulses in;
//        NVL (level code), CN + FROG_RESET (one-cycle reload strobes), RUN,
//        LIVES, GAMEOVER, WIN out -- all registered.
module sc_levelseq
  import sc_levelseq_pkg::*;
#(
  parameter int unsigned DATAWIDTH_NVL = DATAWIDTH_NVL_DEF,
  parameter int unsigned NUM_LEVELS    = NUM_LEVELS_DEF,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned LIVES_WIDTH   = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SETTLE_WIDTH  = 5
) (
  input  logic                     SC_LEVELSEQ_CLOCK_50,
  input  logic                     SC_LEVELSEQ_RESET,
  input  logic                     SC_LEVELSEQ_START_IN,
  input  logic                     SC_LEVELSEQ_GOAL_IN,
  input  logic                     SC_LEVELSEQ_CRASH_IN,
  output logic [DATAWIDTH_NVL-1:0] SC_LEVELSEQ_NVL_OUT,
  output logic                     SC_LEVELSEQ_CN_OUT,
  output logic                     SC_LEVELSEQ_FROG_RESET_OUT,
  output logic                     SC_LEVELSEQ_RUN_OUT,
  output logic [LIVES_WIDTH-1:0]   SC_LEVELSEQ_LIVES_OUT,
  output logic                     SC_LEVELSEQ_GAMEOVER_OUT,
  output logic                     SC_LEVELSEQ_WIN_OUT
);

  localparam logic [DATAWIDTH_NVL-1:0] NVL_TOP    = DATAWIDTH_NVL'(NUM_LEVELS - 1);
  localparam logic [LIVES_WIDTH-1:0]   LIVES_FULL = LIVES_WIDTH'(LIVES_INIT);

  state_e state;
  logic   timer_load_c;
  logic   timer_en_c;
  logic   timer_last;

  // The settle timer is preset during the single LOAD cycle and runs through SETTLE.
  assign timer_load_c = (state == ST_LOAD);
  assign timer_en_c   = (state == ST_SETTLE);

  sc_levelseq_timer #(
    .WIDTH (SETTLE_WIDTH)
  ) u_timer (
    .clk    (SC_LEVELSEQ_CLOCK_50),
    .reset  (SC_LEVELSEQ_RESET),
    .load   (timer_load_c),
    .value  (SETTLE_WIDTH'(SETTLE_CYCLES)),
    .enable (timer_en_c),
    .last   (timer_last)
  );

  // Sequencer FSM; outputs are set on the transition so they are Moore values of
  // the state being entered.
  always_ff @(posedge SC_LEVELSEQ_CLOCK_50) begin
    if (SC_LEVELSEQ_RESET) begin
      state                      <= ST_IDLE;
      SC_LEVELSEQ_NVL_OUT        <= '0;
      SC_LEVELSEQ_LIVES_OUT      <= LIVES_FULL;
      SC_LEVELSEQ_CN_OUT         <= 1'b0;
      SC_LEVELSEQ_FROG_RESET_OUT <= 1'b0;
      SC_LEVELSEQ_RUN_OUT        <= 1'b0;
      SC_LEVELSEQ_GAMEOVER_OUT   <= 1'b0;
      SC_LEVELSEQ_WIN_OUT        <= 1'b0;
    end else begin
      // Reload strobes only ever last the one LOAD cycle.
      SC_LEVELSEQ_CN_OUT         <= 1'b0;
      SC_LEVELSEQ_FROG_RESET_OUT <= 1'b0;

      case (state)
        ST_IDLE, ST_GAMEOVER, ST_WIN: begin
          if (SC_LEVELSEQ_START_IN) begin
            state                      <= ST_LOAD;
            SC_LEVELSEQ_NVL_OUT        <= '0;
            SC_LEVELSEQ_LIVES_OUT      <= LIVES_FULL;
            SC_LEVELSEQ_CN_OUT         <= 1'b1;
            SC_LEVELSEQ_FROG_RESET_OUT <= 1'b1;
            SC_LEVELSEQ_GAMEOVER_OUT   <= 1'b0;
            SC_LEVELSEQ_WIN_OUT        <= 1'b0;
          end
        end

        ST_LOAD: begin
          state <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (timer_last) begin
            state               <= ST_RUN;
            SC_LEVELSEQ_RUN_OUT <= 1'b1;
          end
        end

        ST_RUN: begin
          // CRASH outranks GOAL when both arrive together.
          if (SC_LEVELSEQ_CRASH_IN) begin
            SC_LEVELSEQ_RUN_OUT <= 1'b0;
            if (SC_LEVELSEQ_LIVES_OUT > LIVES_WIDTH'(1)) begin
              state                      <= ST_LOAD;
              SC_LEVELSEQ_LIVES_OUT      <= SC_LEVELSEQ_LIVES_OUT - LIVES_WIDTH'(1);
              SC_LEVELSEQ_CN_OUT         <= 1'b1;
              SC_LEVELSEQ_FROG_RESET_OUT <= 1'b1;
            end else begin
              state                    <= ST_GAMEOVER;
              SC_LEVELSEQ_LIVES_OUT    <= '0;
              SC_LEVELSEQ_GAMEOVER_OUT <= 1'b1;
            end
          end else if (SC_LEVELSEQ_GOAL_IN) begin
            SC_LEVELSEQ_RUN_OUT <= 1'b0;
            if (SC_LEVELSEQ_NVL_OUT < NVL_TOP) begin
              state                      <= ST_LOAD;
              SC_LEVELSEQ_NVL_OUT        <= SC_LEVELSEQ_NVL_OUT + DATAWIDTH_NVL'(1);
              SC_LEVELSEQ_CN_OUT         <= 1'b1;
              SC_LEVELSEQ_FROG_RESET_OUT <= 1'b1;
            end else begin
              state               <= ST_WIN;
              SC_LEVELSEQ_WIN_OUT <= 1'b1;
            end
          end
        end

        default: begin
          state               <= ST_IDLE;
          SC_LEVELSEQ_RUN_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule
